d_cache_2way_write_back: RTL and testbench
==========================================

Name: d_cache_2way_write_back

Overview:
- Parametrised successor to the direct-mapped write-through data cache. Sits between the MIPS core data port and the SRAM-like AXI bridge port; the port set is unchanged.
- 2-way set-associative, one 32-bit word per line, 1-bit LRU per set.
- Write-back with a dirty bit per line, write-allocate.
- Hits complete combinationally in the request cycle. Misses evict the victim, writing it back to memory first if it is dirty, then fill the line.

Parameters:
- INDEX_WIDTH, 10, set index bits; number of sets = 1<<INDEX_WIDTH.
- OFFSET_WIDTH, 2, byte offset bits within a line; fixed at 2 (one word per line).
- TAG_WIDTH (localparam), 32-INDEX_WIDTH-OFFSET_WIDTH, tag bits per line.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_data_req  in  1  core access request
- cpu_data_wr  in  1  1 = store, 0 = load
- cpu_data_size  in  2  00 = byte, 01 = half, 10 = word
- cpu_data_addr  in  32  byte address
- cpu_data_wdata  in  32  store data, lane-aligned
- cpu_data_rdata  out  32  load data
- cpu_data_addr_ok  out  1  request accepted
- cpu_data_data_ok  out  1  access complete
- cache_data_req  out  1  memory request
- cache_data_wr  out  1  memory write
- cache_data_size  out  2  always 2'b10
- cache_data_addr  out  32  word-aligned memory address
- cache_data_wdata  out  32  write-back data
- cache_data_rdata  in  32  fill data
- cache_data_addr_ok  in  1  memory address accepted
- cache_data_data_ok  in  1  memory data done

Behaviour:
- Reset (rst low, async):
  - state = IDLE, cache_data_req = 0.
  - All valid, dirty and lru bits cleared.
  - cpu_data_addr_ok / cpu_data_data_ok = 0.
  - Any in-flight memory transaction is abandoned; the bridge shares the reset.
- Core contract: addr, wr, size and wdata are held stable from req assertion until data_ok.
- Address split: tag = addr[31:12], index = addr[11:2] at the defaults.
- Lookup (IDLE only):
  - hit_w = valid[w][index] & (tag[w][index] == tag).
  - hit = hit0 | hit1; both ways never hit simultaneously.
- Read hit: addr_ok = data_ok = 1 in the same cycle; rdata = block of the hit way; no memory traffic.
- Write hit, same cycle:
  - Byte mask from size and addr[1:0]: byte → 0001/0010/0100/1000; half → 0011/1100 by addr[1]; word → 1111.
  - Merge new = old & ~m | wdata & m; set dirty; addr_ok = data_ok = 1.
- LRU bit names the way to replace next:
  - On any hit to way w, lru <= ~w.
  - On a fill to way v, lru <= ~v.
- Victim on miss: way0 if invalid, else way1 if invalid, else way lru.
- On miss, at the IDLE edge, latch tag, index, wr, size, addr[1:0], wdata, victim way, victim tag and victim block.
- FSM:
  - IDLE → WB if miss and victim valid & dirty.
  - IDLE → RM if miss otherwise.
  - WB → RM on cache_data_data_ok.
  - RM → IDLE on cache_data_data_ok.
- WB: cache_data_wr = 1, addr = {victim_tag, index, 2'b00}, wdata = victim block.
- RM: cache_data_wr = 0, addr = {tag, index, 2'b00}.
- Memory handshake:
  - cache_data_req is asserted on entry to WB/RM and held with stable fields until addr_ok.
  - req is low from the cycle after addr_ok; exactly one request per state.
  - data_ok may arrive in the addr_ok cycle or later.
  - The block never issues a second request before data_ok.
- Fill, at the RM data_ok edge:
  - Victim way: valid = 1, tag = latched tag.
  - Read miss: block = rdata, dirty = 0.
  - Write miss: block = merge of rdata with latched wdata, dirty = 1.
- Miss completion: cpu addr_ok = data_ok = 1 only in the RM data_ok cycle; rdata = cache_data_rdata for loads.
- While not IDLE: a new cpu_data_req is ignored, with no addr_ok and no array writes.
- cache_data_size is always 2'b10.
- cpu addr_ok / data_ok are never asserted without cpu_data_req.

Test Plan:
- Reset, then load 0x00000010: RM request with addr 0x10, wr = 0; memory returns 0xDEADBEEF → data_ok with rdata 0xDEADBEEF. Repeat load → same-cycle data_ok, cache_data_req stays 0.
- Line 0x10 holds 0x11223344; store byte addr 0x11, wdata 0x0000AA00 → same-cycle data_ok, no memory traffic. Load 0x10 → 0x1122AA44.
- Loads 0x0010, 0x1010 (fill both ways); load 0x0010 (hit, LRU→way of 0x1010); load 0x2010 → evicts 0x1010 with no write-back. Load 0x0010 hits; load 0x1010 misses.
- Store word 0xCAFEF00D to 0x0010 (miss, fill, dirty); load 0x1010; load 0x2010 → WB request wr = 1, addr 0x10, wdata 0xCAFEF00D, then RM addr 0x2010, then data_ok.
- Hold cache_data_addr_ok low 5 cycles in RM → req and addr held stable, req drops the cycle after addr_ok, cpu data_ok only with memory data_ok.
- Pull rst low while RM awaits data_ok → req = 0 immediately, state IDLE. After release, load of the same address misses again.

Source files
------------

// File: rtl/d_cache_2way_write_back.sv
// 2-way set-associative, write-back, write-allocate data cache with one word per line.
// Hits finish in the request cycle; misses write back a dirty victim, then refill.
module d_cache_2way_write_back #(
   parameter int INDEX_WIDTH  = 10,
   parameter int OFFSET_WIDTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_data_req,
   input  logic        cpu_data_wr,
   input  logic [1:0]  cpu_data_size,
   input  logic [31:0] cpu_data_addr,
   input  logic [31:0] cpu_data_wdata,
   output logic [31:0] cpu_data_rdata,
   output logic        cpu_data_addr_ok,
   output logic        cpu_data_data_ok,
   output logic        cache_data_req,
   output logic        cache_data_wr,
   output logic [1:0]  cache_data_size,
   output logic [31:0] cache_data_addr,
   output logic [31:0] cache_data_wdata,
   input  logic [31:0] cache_data_rdata,
   input  logic        cache_data_addr_ok,
   input  logic        cache_data_data_ok
);
   localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int SETS      = 1 << INDEX_WIDTH;

   typedef enum logic [1:0] {IDLE, WB, RM} state_t;

   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  m);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      return r;
   endfunction

   state_t state, state_next;
   logic   req_q, req_next;

   logic [1:0][SETS-1:0]  valid, dirty;
   logic [SETS-1:0]       lru;
   logic [TAG_WIDTH-1:0]  tag_mem  [2][SETS];
   logic [31:0]           data_mem [2][SETS];

   logic [TAG_WIDTH-1:0]    tag_q, victim_tag_q;
   logic [INDEX_WIDTH-1:0]  index_q;
   logic [OFFSET_WIDTH-1:0] off_q;
   logic [1:0]              size_q;
   logic [31:0]             wdata_q, victim_data_q;
   logic                    wr_q, victim_q;

   logic [TAG_WIDTH-1:0]    req_tag;
   logic [INDEX_WIDTH-1:0]  req_index;
   logic [OFFSET_WIDTH-1:0] req_off;
   logic                    lookup, hit0, hit1, hit, hit_way, victim, fill;
   logic [31:0]             hit_data;

   assign req_tag   = cpu_data_addr[31 -: TAG_WIDTH];
   assign req_index = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_off   = cpu_data_addr[OFFSET_WIDTH-1:0];

   assign lookup   = (state == IDLE) && cpu_data_req;
   assign hit0     = valid[0][req_index] && (tag_mem[0][req_index] == req_tag);
   assign hit1     = valid[1][req_index] && (tag_mem[1][req_index] == req_tag);
   assign hit      = hit0 || hit1;
   assign hit_way  = hit1;
   assign hit_data = hit1 ? data_mem[1][req_index] : data_mem[0][req_index];
   assign victim   = !valid[0][req_index] ? 1'b0 :
                     !valid[1][req_index] ? 1'b1 : lru[req_index];
   assign fill     = (state == RM) && cache_data_data_ok;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      req_next   = req_q;
      case (state)
         IDLE: if (lookup && !hit) begin
            state_next = (valid[victim][req_index] && dirty[victim][req_index]) ? WB : RM;
            req_next   = 1'b1;
         end
         WB: begin
            if (req_q && cache_data_addr_ok) req_next = 1'b0;
            if (cache_data_data_ok) begin
               state_next = RM;
               req_next   = 1'b1;
            end
         end
         RM: begin
            if (req_q && cache_data_addr_ok) req_next = 1'b0;
            if (cache_data_data_ok) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign cache_data_req   = req_q;
   assign cache_data_wr    = (state == WB);
   assign cache_data_size  = 2'b10;
   assign cache_data_addr  = (state == WB) ? {victim_tag_q, index_q, {OFFSET_WIDTH{1'b0}}}
                                           : {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
   assign cache_data_wdata = victim_data_q;

   assign cpu_data_addr_ok = cpu_data_req && ((lookup && hit) || fill);
   assign cpu_data_data_ok = cpu_data_addr_ok;
   assign cpu_data_rdata   = (state == RM) ? cache_data_rdata : hit_data;

   // NOTE: sequential state uses <= so every reader on this edge sees the pre-edge value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         req_q         <= 1'b0;
         valid         <= '0;
         dirty         <= '0;
         lru           <= '0;
         tag_q         <= '0;
         index_q       <= '0;
         off_q         <= '0;
         size_q        <= '0;
         wr_q          <= 1'b0;
         wdata_q       <= '0;
         victim_q      <= 1'b0;
         victim_tag_q  <= '0;
         victim_data_q <= '0;
      end else begin
         state <= state_next;
         req_q <= req_next;
         if (lookup && hit) begin
            lru[req_index] <= ~hit_way;
            if (cpu_data_wr) dirty[hit_way][req_index] <= 1'b1;
         end
         if (lookup && !hit) begin
            tag_q         <= req_tag;
            index_q       <= req_index;
            off_q         <= req_off;
            size_q        <= cpu_data_size;
            wr_q          <= cpu_data_wr;
            wdata_q       <= cpu_data_wdata;
            victim_q      <= victim;
            victim_tag_q  <= tag_mem[victim][req_index];
            victim_data_q <= data_mem[victim][req_index];
         end
         if (fill) begin
            valid[victim_q][index_q] <= 1'b1;
            dirty[victim_q][index_q] <= wr_q;
            lru[index_q]             <= ~victim_q;
         end
      end
   end

   // NOTE: tag/data arrays have no reset; the cleared valid bits keep stale contents unseen.
   always_ff @(posedge clk) begin
      if (lookup && hit && cpu_data_wr)
         data_mem[hit_way][req_index] <= merge_word(hit_data, cpu_data_wdata,
                                                    byte_mask(cpu_data_size, req_off));
      if (fill) begin
         tag_mem[victim_q][index_q]  <= tag_q;
         data_mem[victim_q][index_q] <= wr_q ? merge_word(cache_data_rdata, wdata_q,
                                                          byte_mask(size_q, off_q))
                                             : cache_data_rdata;
      end
   end
endmodule

// File: tb/tb_d_cache_2way_write_back.sv
// Directed bench: the bench plays both the core and the memory bridge, with
// hand-computed line contents, LRU victims and write-back traffic.
module tb_d_cache_2way_write_back;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_data_req = 1'b0;
   logic        cpu_data_wr = 1'b0;
   logic [1:0]  cpu_data_size = 2'b10;
   logic [31:0] cpu_data_addr = '0;
   logic [31:0] cpu_data_wdata = '0;
   logic [31:0] cpu_data_rdata;
   logic        cpu_data_addr_ok, cpu_data_data_ok;
   logic        cache_data_req, cache_data_wr;
   logic [1:0]  cache_data_size;
   logic [31:0] cache_data_addr, cache_data_wdata;
   logic [31:0] cache_data_rdata = '0;
   logic        cache_data_addr_ok = 1'b0;
   logic        cache_data_data_ok = 1'b0;

   int checks = 0;
   int errors = 0;

   d_cache_2way_write_back dut (
      .clk(clk), .rst(rst),
      .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
      .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
      .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
      .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
      .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
      .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
      .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
      .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      cpu_data_req = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic drive_cpu(input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
      cpu_data_req   = 1'b1;
      cpu_data_wr    = wr;
      cpu_data_size  = size;
      cpu_data_addr  = addr;
      cpu_data_wdata = wdata;
   endtask

   // Access expected to hit: completes in the request cycle, no memory request.
   task automatic cpu_hit(input string nm, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata);
      @(negedge clk);
      drive_cpu(wr, size, addr, wdata);
      #1;
      check({nm, "_addr_ok"}, {31'd0, cpu_data_addr_ok}, 32'd1);
      check({nm, "_data_ok"}, {31'd0, cpu_data_data_ok}, 32'd1);
      check({nm, "_mem_req"}, {31'd0, cache_data_req}, 32'd0);
      if (!wr) check({nm, "_rdata"}, cpu_data_rdata, exp_rdata);
      @(negedge clk);
      cpu_data_req = 1'b0;
   endtask

   // Access expected to miss: no completion in the request cycle.
   task automatic cpu_miss(input string nm, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      drive_cpu(wr, size, addr, wdata);
      #1;
      check({nm, "_miss_data_ok"}, {31'd0, cpu_data_data_ok}, 32'd0);
      check({nm, "_miss_addr_ok"}, {31'd0, cpu_data_addr_ok}, 32'd0);
   endtask

   // Serve one memory transaction; last = 1 for the refill that completes the core access.
   task automatic mem_serve(input string nm, input logic exp_wr, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [31:0] rd,
                            input int stall, input int gap, input logic last,
                            input logic chk_rdata);
      int n;
      n = 0;
      while (cache_data_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({nm, "_req"}, {31'd0, cache_data_req}, 32'd1);
      check({nm, "_wr"}, {31'd0, cache_data_wr}, {31'd0, exp_wr});
      check({nm, "_addr"}, cache_data_addr, exp_addr);
      check({nm, "_size"}, {30'd0, cache_data_size}, 32'd2);
      if (exp_wr) check({nm, "_wdata"}, cache_data_wdata, exp_wdata);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         #1;
         check({nm, "_req_hold"}, {31'd0, cache_data_req}, 32'd1);
         check({nm, "_addr_hold"}, cache_data_addr, exp_addr);
         check({nm, "_cpu_wait"}, {31'd0, cpu_data_data_ok}, 32'd0);
      end
      cache_data_addr_ok = 1'b1;
      cache_data_rdata   = rd;
      for (int i = 0; i < gap; i++) begin
         #1;
         check({nm, "_cpu_early"}, {31'd0, cpu_data_data_ok}, 32'd0);
         @(negedge clk);
         cache_data_addr_ok = 1'b0;
         #1;
         check({nm, "_req_drop"}, {31'd0, cache_data_req}, 32'd0);
      end
      cache_data_data_ok = 1'b1;
      #1;
      check({nm, "_cpu_data_ok"}, {31'd0, cpu_data_data_ok}, {31'd0, last});
      check({nm, "_cpu_addr_ok"}, {31'd0, cpu_data_addr_ok}, {31'd0, last});
      if (last && chk_rdata) check({nm, "_cpu_rdata"}, cpu_data_rdata, rd);
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      #1;
      check({nm, "_req_after"}, {31'd0, cache_data_req}, {31'd0, !last});
      if (last) cpu_data_req = 1'b0;
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_mem_req", {31'd0, cache_data_req}, 32'd0);
      check("rst_addr_ok", {31'd0, cpu_data_addr_ok}, 32'd0);
      check("rst_data_ok", {31'd0, cpu_data_data_ok}, 32'd0);
      check("rst_size", {30'd0, cache_data_size}, 32'd2);
      @(negedge clk);
      rst = 1'b1;

      // Refill, hit, byte and half stores merged into a dirty line
      cpu_miss("a1", 1'b0, 2'b10, 32'h0000_0010, '0);
      mem_serve("a1_rm", 1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF, 0, 0, 1'b1, 1'b1);
      cpu_hit("a2", 1'b0, 2'b10, 32'h0000_0010, '0, 32'hDEAD_BEEF);
      cpu_hit("a3", 1'b1, 2'b10, 32'h0000_0010, 32'h1122_3344, '0);
      cpu_hit("a4", 1'b1, 2'b00, 32'h0000_0011, 32'h0000_AA00, '0);
      cpu_hit("a5", 1'b0, 2'b10, 32'h0000_0010, '0, 32'h1122_AA44);
      cpu_hit("a6", 1'b1, 2'b01, 32'h0000_0012, 32'h5566_0000, '0);
      cpu_hit("a6r", 1'b0, 2'b10, 32'h0000_0010, '0, 32'h5566_AA44);
      cpu_miss("a7", 1'b0, 2'b10, 32'h0000_1010, '0);
      mem_serve("a7_rm", 1'b0, 32'h0000_1010, '0, 32'h0101_0101, 0, 0, 1'b1, 1'b1);
      // Dirty victim: write-back, then refill with address-accept stall and late data
      cpu_miss("a8", 1'b0, 2'b10, 32'h0000_2010, '0);
      mem_serve("a8_wb", 1'b1, 32'h0000_0010, 32'h5566_AA44, '0, 0, 0, 1'b0, 1'b0);
      mem_serve("a8_rm", 1'b0, 32'h0000_2010, '0, 32'h0202_0202, 5, 2, 1'b1, 1'b1);
      cpu_hit("a9", 1'b0, 2'b10, 32'h0000_1010, '0, 32'h0101_0101);
      cpu_hit("a10", 1'b0, 2'b10, 32'h0000_2010, '0, 32'h0202_0202);

      // LRU replacement on clean lines
      do_reset();
      cpu_miss("b1", 1'b0, 2'b10, 32'h0000_0010, '0);
      mem_serve("b1_rm", 1'b0, 32'h0000_0010, '0, 32'hA0A0_A0A0, 0, 0, 1'b1, 1'b1);
      cpu_miss("b2", 1'b0, 2'b10, 32'h0000_1010, '0);
      mem_serve("b2_rm", 1'b0, 32'h0000_1010, '0, 32'hB1B1_B1B1, 0, 0, 1'b1, 1'b1);
      cpu_hit("b3", 1'b0, 2'b10, 32'h0000_0010, '0, 32'hA0A0_A0A0);
      cpu_miss("b4", 1'b0, 2'b10, 32'h0000_2010, '0);
      mem_serve("b4_rm", 1'b0, 32'h0000_2010, '0, 32'hC2C2_C2C2, 1, 1, 1'b1, 1'b1);
      cpu_hit("b5", 1'b0, 2'b10, 32'h0000_0010, '0, 32'hA0A0_A0A0);
      cpu_miss("b6", 1'b0, 2'b10, 32'h0000_1010, '0);
      mem_serve("b6_rm", 1'b0, 32'h0000_1010, '0, 32'hB1B1_B1B1, 0, 0, 1'b1, 1'b1);

      // Write-allocate misses and dirty write-back
      do_reset();
      cpu_miss("c1", 1'b1, 2'b10, 32'h0000_0010, 32'hCAFE_F00D);
      mem_serve("c1_rm", 1'b0, 32'h0000_0010, '0, 32'h1234_5678, 0, 0, 1'b1, 1'b0);
      cpu_hit("c2", 1'b0, 2'b10, 32'h0000_0010, '0, 32'hCAFE_F00D);
      cpu_miss("c3", 1'b1, 2'b00, 32'h0000_0023, 32'h7700_0000);
      mem_serve("c3_rm", 1'b0, 32'h0000_0020, '0, 32'h1111_1111, 0, 0, 1'b1, 1'b0);
      cpu_hit("c3r", 1'b0, 2'b10, 32'h0000_0020, '0, 32'h7711_1111);
      cpu_miss("c4", 1'b0, 2'b10, 32'h0000_1010, '0);
      mem_serve("c4_rm", 1'b0, 32'h0000_1010, '0, 32'h0F0F_0F0F, 0, 0, 1'b1, 1'b1);
      cpu_miss("c5", 1'b0, 2'b10, 32'h0000_2010, '0);
      mem_serve("c5_wb", 1'b1, 32'h0000_0010, 32'hCAFE_F00D, '0, 0, 1, 1'b0, 1'b0);
      mem_serve("c5_rm", 1'b0, 32'h0000_2010, '0, 32'h2020_2020, 0, 0, 1'b1, 1'b1);
      cpu_miss("c6", 1'b0, 2'b10, 32'h0000_0010, '0);
      mem_serve("c6_rm", 1'b0, 32'h0000_0010, '0, 32'hCAFE_F00D, 0, 0, 1'b1, 1'b1);

      // Reset while a refill is outstanding
      do_reset();
      cpu_miss("d1", 1'b0, 2'b10, 32'h0000_0040, '0);
      @(negedge clk);
      #1;
      check("d1_rm_req", {31'd0, cache_data_req}, 32'd1);
      rst = 1'b0;
      #1;
      check("d1_rst_req", {31'd0, cache_data_req}, 32'd0);
      check("d1_rst_data_ok", {31'd0, cpu_data_data_ok}, 32'd0);
      cpu_data_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      cpu_miss("d2", 1'b0, 2'b10, 32'h0000_0040, '0);
      mem_serve("d2_rm", 1'b0, 32'h0000_0040, '0, 32'h4444_4444, 0, 0, 1'b1, 1'b1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
